// File: rtl/serial_seq_gen_pkg.sv
// Shared definitions for the serial sequence generator: state encoding and default word width.
package serial_seq_gen_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t GAP   = 2'd2;

endpackage

// File: rtl/serial_seq_gen_history.sv
// Two-bit emitted-bit history with saturating fill count; predicts the overlapping
// Mealy 111/000 detector output for the bit currently on x.
module seq_history (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic bit_valid,
  output logic expect_y
);

  logic [1:0] h;
  logic [1:0] fill;

  always_ff @(posedge clk) begin
    if (!rst) begin
      h    <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      h <= {h[0], x};
      if (fill != 2'd2) fill <= fill + 2'd1;
    end
  end

  assign expect_y = bit_valid && (fill == 2'd2) && (x == h[1]) && (x == h[0]);

endmodule

// File: rtl/serial_seq_gen.sv
// Serialises variable-length words MSB-first with optional inter-word gap and
// a golden expect_y prediction for a downstream 111/000 detector.
module serial_seq_gen
  import serial_seq_gen_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH):0]     len_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  output logic                       x,
  output logic                       bit_valid,
  output logic                       last_bit,
  output logic                       expect_y
);

  localparam int LW = $clog2(WIDTH) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LW-1:0] FULL = LW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] aligned;
  logic [LW-1:0]    count;
  logic [LW-1:0]    eff_len;
  logic [GW-1:0]    gap_cnt;
  logic             ready_en;
  logic             accept;

  // ready_en keeps ready_out low for as long as reset is being sampled.
  assign last_bit = (state == SHIFT) && (count == '0);
  assign accept   = valid_in && ready_out;

  always_comb begin
    ready_out = 1'b0;
    if (ready_en) begin
      case (state)
        IDLE:    ready_out = 1'b1;
        SHIFT:   ready_out = (GAP_CYCLES == 0) && last_bit;
        default: ready_out = 1'b0;
      endcase
    end
  end

  always_comb begin
    eff_len = len_in;
    if (len_in == '0 || len_in > FULL) eff_len = FULL;
  end

  // Left-align the active field so the MSB of the word is always shreg's top bit.
  assign aligned = data_in << (FULL - eff_len);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      count     <= '0;
      gap_cnt   <= '0;
      x         <= 1'b0;
      bit_valid <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        state     <= SHIFT;
        count     <= eff_len - 1'b1;
        x         <= aligned[WIDTH-1];
        shreg     <= aligned << 1;
        bit_valid <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            if (count != '0) begin
              count <= count - 1'b1;
              x     <= shreg[WIDTH-1];
              shreg <= shreg << 1;
            end else begin
              x         <= 1'b0;
              bit_valid <= 1'b0;
              gap_cnt   <= '0;
              state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end
          end
          GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
            else gap_cnt <= gap_cnt + 1'b1;
          end
          default: begin
            state     <= IDLE;
            x         <= 1'b0;
            bit_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  seq_history u_history (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .bit_valid (bit_valid),
    .expect_y  (expect_y)
  );

endmodule

// File: tb/tb_serial_seq_gen.sv
// Self-checking bench: two generator instances (no gap / two-cycle gap) checked
// against a bit-stream reference model built from the words offered.
module tb_serial_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] data0 = '0, data2 = '0;
  logic [3:0] len0 = '0, len2 = '0;
  logic       valid0 = 1'b0, valid2 = 1'b0;
  logic       ready0, x0, bv0, last0, ey0;
  logic       ready2, x2, bv2, last2, ey2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] wq_d[$];
  int         wq_l[$];
  bit         bits0[$];
  bit         bits2[$];

  always #5 clk = ~clk;

  serial_seq_gen #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data0), .len_in(len0), .valid_in(valid0),
    .ready_out(ready0), .x(x0), .bit_valid(bv0), .last_bit(last0), .expect_y(ey0)
  );

  serial_seq_gen #(.WIDTH(8), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data2), .len_in(len2), .valid_in(valid2),
    .ready_out(ready2), .x(x2), .bit_valid(bv2), .last_bit(last2), .expect_y(ey2)
  );

  // Detector prediction: the bit equals each of the two previous stream bits since reset.
  function automatic bit pred(input bit b, input bit hist[$]);
    int n = hist.size();
    return (n >= 2) && (hist[n-1] == b) && (hist[n-2] == b);
  endfunction

  function automatic int eff_len(input int l);
    return (l == 0 || l > 8) ? 8 : l;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({x0, bv0, last0, ey0, ready0} !== 5'b0) begin n_fail++;
      $display("FAIL reset_outs0 got %b expected 00000", {x0, bv0, last0, ey0, ready0}); end
    n_checks++; if ({x2, bv2, last2, ey2, ready2} !== 5'b0) begin n_fail++;
      $display("FAIL reset_outs2 got %b expected 00000", {x2, bv2, last2, ey2, ready2}); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ready0 !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready_pending got %b expected 0", ready0); end
    @(negedge clk);
    n_checks++; if (ready0 !== 1'b1 || ready2 !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready_after got %b%b expected 11", ready0, ready2); end
    bits0.delete(); bits2.delete();
  endtask

  // Offers the queued words to dut0 with valid held high; each word follows on last_bit.
  task automatic play0(input string name);
    bit eb[$]; bit el[$]; int wi; int L; logic [7:0] d; bit ey;
    for (int w = 0; w < wq_d.size(); w++) begin
      d = wq_d[w]; L = eff_len(wq_l[w]);
      for (int k = L - 1; k >= 0; k--) begin eb.push_back(d[k]); el.push_back(k == 0); end
    end
    @(posedge clk); #1;
    data0 = wq_d[0]; len0 = 4'(wq_l[0]); valid0 = 1'b1;
    n_checks++; if (ready0 !== 1'b1) begin n_fail++;
      $display("FAIL %s ready_idle got %b expected 1", name, ready0); end
    wi = 1;
    for (int i = 0; i < eb.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0 || el[i-1]) begin
        if (wi < wq_d.size()) begin data0 = wq_d[wi]; len0 = 4'(wq_l[wi]); wi++; end
        else begin valid0 = 1'b0; data0 = 8'($urandom); len0 = 4'($urandom); end
      end
      @(negedge clk);
      ey = pred(eb[i], bits0);
      n_checks++; if (x0 !== eb[i] || bv0 !== 1'b1) begin n_fail++;
        $display("FAIL %s bit%0d x/bv got %b%b expected %b1", name, i, x0, bv0, eb[i]); end
      n_checks++; if (last0 !== el[i]) begin n_fail++;
        $display("FAIL %s bit%0d last_bit got %b expected %b", name, i, last0, el[i]); end
      n_checks++; if (ey0 !== ey) begin n_fail++;
        $display("FAIL %s bit%0d expect_y got %b expected %b", name, i, ey0, ey); end
      bits0.push_back(eb[i]);
    end
    @(negedge clk);
    n_checks++; if ({x0, bv0, last0, ready0} !== 4'b0001) begin n_fail++;
      $display("FAIL %s after_word got %b expected 0001", name, {x0, bv0, last0, ready0}); end
    wq_d.delete(); wq_l.delete();
  endtask

  task automatic test_single();
    wq_d.push_back(8'b0001_1110); wq_l.push_back(8);
    play0("single");
  endtask

  task automatic test_back_to_back();
    wq_d.push_back(8'b0000_0011); wq_l.push_back(2);
    wq_d.push_back(8'b0000_0001); wq_l.push_back(1);
    play0("back_to_back");
  endtask

  task automatic test_len_zero();
    wq_d.push_back(8'hA5); wq_l.push_back(0);
    play0("len_zero");
  endtask

  task automatic test_clamp();
    wq_d.push_back(8'($urandom)); wq_l.push_back(int'($urandom_range(9, 15)));
    play0("clamp");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++) begin
        wq_d.push_back(8'($urandom)); wq_l.push_back(int'($urandom_range(0, 15)));
      end
      play0("random");
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d; bit ey; bit b;
    d = 8'($urandom);
    @(posedge clk); #1 data0 = d; len0 = 4'd8; valid0 = 1'b1;
    @(posedge clk); #1 valid0 = 1'b0; data0 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b = d[7-i]; ey = pred(b, bits0);
      n_checks++; if (x0 !== b || bv0 !== 1'b1 || last0 !== (i == 7)) begin n_fail++;
        $display("FAIL busy bit%0d x/bv/last got %b%b%b expected %b1%b", i, x0, bv0, last0, b, i == 7); end
      n_checks++; if (ready0 !== (i == 7) || ey0 !== ey) begin n_fail++;
        $display("FAIL busy bit%0d ready/expect_y got %b%b expected %b%b", i, ready0, ey0, i == 7, ey); end
      bits0.push_back(b);
      @(posedge clk); #1;
      valid0 = (i <= 5) ? 1'($urandom) : 1'b0;
      data0 = 8'($urandom); len0 = 4'($urandom);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (bv0 !== 1'b0 || ready0 !== 1'b1) begin n_fail++;
        $display("FAIL busy no_extra_word bv/ready got %b%b expected 01", bv0, ready0); end
    end
  endtask

  task automatic test_gap();
    for (int r = 0; r < 3; r++) begin
      logic [7:0] d[2]; int L[2]; int lr[2]; bit b; bit ey;
      for (int w = 0; w < 2; w++) begin
        d[w] = 8'($urandom); lr[w] = int'($urandom_range(0, 15)); L[w] = eff_len(lr[w]);
      end
      @(posedge clk); #1 data2 = d[0]; len2 = 4'(lr[0]); valid2 = 1'b1;
      @(posedge clk); #1 data2 = d[1]; len2 = 4'(lr[1]);
      for (int w = 0; w < 2; w++) begin
        for (int k = L[w] - 1; k >= 0; k--) begin
          @(negedge clk);
          b = d[w][k]; ey = pred(b, bits2);
          n_checks++; if (x2 !== b || bv2 !== 1'b1 || last2 !== (k == 0)) begin n_fail++;
            $display("FAIL gap w%0d bit%0d x/bv/last got %b%b%b expected %b1%b", w, k, x2, bv2, last2, b, k == 0); end
          n_checks++; if (ready2 !== 1'b0 || ey0 !== ey0 || ey2 !== ey) begin n_fail++;
            $display("FAIL gap w%0d bit%0d ready/expect_y got %b%b expected 0%b", w, k, ready2, ey2, ey); end
          bits2.push_back(b);
          @(posedge clk);
        end
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          n_checks++; if ({x2, bv2, ready2} !== 3'b000) begin n_fail++;
            $display("FAIL gap w%0d gap%0d x/bv/ready got %b expected 000", w, g, {x2, bv2, ready2}); end
          @(posedge clk);
        end
        @(negedge clk);
        n_checks++; if (bv2 !== 1'b0 || ready2 !== 1'b1) begin n_fail++;
          $display("FAIL gap w%0d idle bv/ready got %b%b expected 01", w, bv2, ready2); end
        if (w == 0) begin @(posedge clk); #1 valid2 = 1'b0; data2 = 8'($urandom); end
      end
    end
  endtask

  task automatic test_reset_midword();
    @(posedge clk); #1 data0 = 8'hFF; len0 = 4'd8; valid0 = 1'b1;
    @(posedge clk); #1 valid0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (x0 !== 1'b1 || bv0 !== 1'b1) begin n_fail++;
      $display("FAIL midword_pre x/bv got %b%b expected 11", x0, bv0); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({x0, bv0, last0, ey0, ready0} !== 5'b0) begin n_fail++;
      $display("FAIL midword_reset outs got %b expected 00000", {x0, bv0, last0, ey0, ready0}); end
    @(posedge clk); #1 rst = 1'b1;
    bits0.delete(); bits2.delete();
    @(negedge clk);
    n_checks++; if (bv0 !== 1'b0) begin n_fail++;
      $display("FAIL midword_no_residue bv got %b expected 0", bv0); end
    wq_d.push_back(8'h07); wq_l.push_back(8);
    play0("after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_len_zero();
    test_clamp();
    test_random();
    test_busy_ignore();
    test_gap();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
